// File: rtl/button_press_gen.sv
// Turns a requested press count into clean button press/release pulses and tracks the predicted toggle state.
// Optional `define BUTTON_GEN_FEEDBACK_EN adds a stateful_button input and a sticky mismatch output.
module button_press_gen #(
    parameter int PRESS_CYCLES   = 2,
    parameter int RELEASE_CYCLES = 2,
    parameter int CNT_W          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_presses,
    output logic             button,
    output logic             busy,
    output logic             done,
`ifdef BUTTON_GEN_FEEDBACK_EN
    input  logic             stateful_button,
    output logic             mismatch,
`endif
    output logic             model_state
);

    localparam int PH_MAX = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] PRESS_LAST   = PH_W'(PRESS_CYCLES - 1);
    localparam logic [PH_W-1:0] RELEASE_LAST = PH_W'(RELEASE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS, RELEASE, DONE} state_t;

    state_t           state;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] remaining;

    // NOTE: every register here is updated with <= so all state moves together on the edge;
    // blocking assignments would let later statements see half-updated values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= '0;
            remaining   <= '0;
            req_ready   <= 1'b1;
            button      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            model_state <= 1'b0;
`ifdef BUTTON_GEN_FEEDBACK_EN
            mismatch    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        phase     <= '0;
`ifdef BUTTON_GEN_FEEDBACK_EN
                        mismatch  <= 1'b0;
`endif
                        if (req_presses != '0) begin
                            state       <= PRESS;
                            remaining   <= req_presses;
                            button      <= 1'b1;
                            busy        <= 1'b1;
                            model_state <= ~model_state;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                PRESS: begin
                    if (phase == PRESS_LAST) begin
                        phase  <= '0;
                        state  <= RELEASE;
                        button <= 1'b0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                RELEASE: begin
                    if (phase == RELEASE_LAST) begin
                        phase     <= '0;
                        remaining <= remaining - 1'b1;
`ifdef BUTTON_GEN_FEEDBACK_EN
                        if (stateful_button != model_state)
                            mismatch <= 1'b1;
`endif
                        // remaining==1 here means the press just finished was the last one
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state       <= PRESS;
                            button      <= 1'b1;
                            model_state <= ~model_state;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
